// File: rtl/mux_sched_pkg.sv
// Shared types and helpers for the 6-channel round-robin selector scheduler.
// Channel indices are always kept in 0..NCH-1; the helpers wrap modulo NCH.
package mux_sched_pkg;

    localparam int NCH  = 6;
    localparam int SELW = 3;

    typedef logic [SELW-1:0] idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Modulo-NCH add; b is always below NCH so one conditional subtract suffices.
    function automatic idx_t idx_add(input idx_t a, input int unsigned b);
        int unsigned s;
        s = 32'(a) + b;
        if (s >= NCH) begin
            s = s - NCH;
        end
        return idx_t'(s);
    endfunction

    function automatic logic [NCH-1:0] onehot(input idx_t i);
        logic [NCH-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requesting channel scanning
// start, start+1, ... modulo NCH, covering every channel exactly once.
module rr_pick
    import mux_sched_pkg::*;
(
    input  logic [NCH-1:0] req,
    input  idx_t           start,
    output logic           found,
    output idx_t           idx
);

    idx_t pos [NCH];

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_pos
            assign pos[gi] = idx_add(start, gi);
        end
    endgenerate

    // Walk from the far end so the position closest to start wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (req[pos[k]]) begin
                found = 1'b1;
                idx   = pos[k];
            end
        end
    end

endmodule

// File: rtl/mux_sel_scheduler.sv
// Round-robin scheduler driving the 6-to-1 selector's sel input, holding each
// winner for up to MAX_BURST handshaked beats with back-to-back re-grants.
module mux_sel_scheduler
    import mux_sched_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           areset_n,
    input  logic [NCH-1:0] req,
    input  logic           out_ready,
    output idx_t           sel,
    output logic           sel_valid,
    output logic [NCH-1:0] grant,
    output logic           burst_last
);

    localparam logic [3:0] CNT_LAST = 4'(MAX_BURST - 1);

    state_t         state_q,     state_d;
    idx_t           sel_q,       sel_d;
    logic           sel_valid_q, sel_valid_d;
    logic [NCH-1:0] grant_q,     grant_d;
    logic [3:0]     beat_cnt_q,  beat_cnt_d;
    idx_t           last_ptr_q,  last_ptr_d;

    logic beat;
    logic at_limit;
    logic sel_req;
    logic rel_beat;
    idx_t pick_base;
    idx_t pick_start;
    logic pick_found;
    idx_t pick_idx;

    assign beat     = sel_valid_q && out_ready;
    assign at_limit = (beat_cnt_q == CNT_LAST);
    assign sel_req  = req[sel_q];
    assign rel_beat = beat && (at_limit || !sel_req);

    // One picker serves both paths: from IDLE the scan follows last_ptr, on a
    // release it follows the channel being released.
    assign pick_base  = (state_q == GRANT) ? sel_q : last_ptr_q;
    assign pick_start = idx_add(pick_base, 1);

    rr_pick u_pick (
        .req   (req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
        grant_d     = grant_q;
        beat_cnt_d  = beat_cnt_q;
        last_ptr_d  = last_ptr_q;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = GRANT;
                    sel_d       = pick_idx;
                    sel_valid_d = 1'b1;
                    grant_d     = onehot(pick_idx);
                    beat_cnt_d  = '0;
                end
            end
            GRANT: begin
                if (rel_beat) begin
                    last_ptr_d = sel_q;
                    beat_cnt_d = '0;
                    if (pick_found) begin
                        sel_d   = pick_idx;
                        grant_d = onehot(pick_idx);
                    end else begin
                        state_d     = IDLE;
                        sel_valid_d = 1'b0;
                        grant_d     = '0;
                    end
                end else if (beat) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            grant_q     <= '0;
            beat_cnt_q  <= '0;
            last_ptr_q  <= idx_t'(NCH - 1);
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            grant_q     <= grant_d;
            beat_cnt_q  <= beat_cnt_d;
            last_ptr_q  <= last_ptr_d;
        end
    end

    assign sel        = sel_q;
    assign sel_valid  = sel_valid_q;
    assign grant      = grant_q;
    assign burst_last = sel_valid_q && (at_limit || !sel_req);

endmodule

// File: tb/tb_mux_sel_scheduler.sv
// Directed bench for mux_sel_scheduler: a MAX_BURST=4 instance and a
// MAX_BURST=1 instance, checked against a hand-computed per-cycle table.
module tb_mux_sel_scheduler;

    logic       clk;
    logic       areset_n;
    logic [5:0] req_a, req_b;
    logic       rdy_a, rdy_b;
    logic [2:0] sel_a, sel_b;
    logic       vld_a, vld_b;
    logic [5:0] gnt_a, gnt_b;
    logic       last_a, last_b;

    int n_assert = 0;
    int n_fail   = 0;

    mux_sel_scheduler #(.MAX_BURST(4)) dut_a (
        .clk        (clk),
        .areset_n   (areset_n),
        .req        (req_a),
        .out_ready  (rdy_a),
        .sel        (sel_a),
        .sel_valid  (vld_a),
        .grant      (gnt_a),
        .burst_last (last_a)
    );

    mux_sel_scheduler #(.MAX_BURST(1)) dut_b (
        .clk        (clk),
        .areset_n   (areset_n),
        .req        (req_b),
        .out_ready  (rdy_b),
        .sel        (sel_b),
        .sel_valid  (vld_b),
        .grant      (gnt_b),
        .burst_last (last_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit         rst;
        bit         b;
        logic [5:0] req;
        bit         rdy;
        logic [2:0] sel;
        bit         vld;
        bit         last;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input bit b, input logic [5:0] req, input bit rdy,
                       input logic [2:0] sel, input bit vld, input bit last);
        vec_t v;
        v.rst = rst; v.b = b; v.req = req; v.rdy = rdy;
        v.sel = sel; v.vld = vld; v.last = last;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] exp_grant(input logic [2:0] s, input bit v);
        logic [5:0] g;
        g = '0;
        if (v) g[s] = 1'b1;
        return g;
    endfunction

    task automatic check_all(input string tag, input bit b, input logic [2:0] s,
                             input bit v, input bit l);
        logic [2:0] as;
        logic       av, al;
        logic [5:0] ag;
        as = b ? sel_b  : sel_a;
        av = b ? vld_b  : vld_a;
        ag = b ? gnt_b  : gnt_a;
        al = b ? last_b : last_a;
        check({tag, " sel"},        32'(as), 32'(s));
        check({tag, " sel_valid"},  32'(av), 32'(v));
        check({tag, " grant"},      32'(ag), 32'(exp_grant(s, v)));
        check({tag, " burst_last"}, 32'(al), 32'(l));
        $display("%s dut=%s req=%b rdy=%0d -> sel=%0d vld=%0d grant=%b last=%0d",
                 tag, b ? "mb1" : "mb4", b ? req_b : req_a, b ? rdy_b : rdy_a, as, av, ag, al);
    endtask

    initial begin
        areset_n = 1'b0;
        req_a = '0; req_b = '0; rdy_a = 1'b0; rdy_b = 1'b0;
        #12;
        check_all("reset", 1'b0, 3'd0, 1'b0, 1'b0);
        areset_n = 1'b1;

        // Reset in the middle of a burst on ch2 (beat_cnt=2).
        req_a = 6'b000100; rdy_a = 1'b1;
        @(posedge clk); #1;
        check_all("mid_rst grant", 1'b0, 3'd2, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_all("mid_rst cnt2", 1'b0, 3'd2, 1'b1, 1'b0);
        #1 areset_n = 1'b0;
        #1;
        check_all("mid_rst async", 1'b0, 3'd0, 1'b0, 1'b0);
        #1 areset_n = 1'b1;
        #1;
        check_all("mid_rst idle", 1'b0, 3'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_all("mid_rst regrant", 1'b0, 3'd2, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_all("mid_rst cnt_cleared", 1'b0, 3'd2, 1'b1, 1'b1);

        // Single requester ch2: 4-beat burst, back-to-back re-grant, hold, drop.
        add(1,0,6'h00,0, 0,0,0);
        add(0,0,6'h04,1, 0,0,0);
        add(0,0,6'h04,1, 2,1,0);
        add(0,0,6'h04,1, 2,1,0);
        add(0,0,6'h04,1, 2,1,0);
        add(0,0,6'h04,1, 2,1,1);
        add(0,0,6'h04,1, 2,1,0);
        add(0,0,6'h00,0, 2,1,1);
        add(0,0,6'h00,0, 2,1,1);
        add(0,0,6'h00,1, 2,1,1);
        add(0,0,6'h00,0, 2,0,0);
        // Wrap between ch5 and ch0 with no bubble.
        add(1,0,6'h00,0, 0,0,0);
        add(0,0,6'h21,1, 0,0,0);
        add(0,0,6'h21,1, 0,1,0);
        add(0,0,6'h21,1, 0,1,0);
        add(0,0,6'h21,1, 0,1,0);
        add(0,0,6'h21,1, 0,1,1);
        add(0,0,6'h21,1, 5,1,0);
        add(0,0,6'h21,1, 5,1,0);
        add(0,0,6'h21,1, 5,1,0);
        add(0,0,6'h21,1, 5,1,1);
        add(0,0,6'h21,1, 0,1,0);
        add(0,0,6'h00,0, 0,1,1);
        add(0,0,6'h00,1, 0,1,1);
        add(0,0,6'h00,0, 0,0,0);
        // Backpressure on ch1 mid-burst.
        add(0,0,6'h02,1, 0,0,0);
        add(0,0,6'h02,1, 1,1,0);
        add(0,0,6'h02,0, 1,1,0);
        add(0,0,6'h02,0, 1,1,0);
        add(0,0,6'h02,0, 1,1,0);
        add(0,0,6'h02,1, 1,1,0);
        add(0,0,6'h02,1, 1,1,0);
        add(0,0,6'h02,1, 1,1,1);
        add(0,0,6'h00,1, 1,1,1);
        add(0,0,6'h00,0, 1,0,0);
        // Early drop on ch3; scan 4,5,0,1 picks ch1 over ch2.
        add(0,0,6'h08,1, 1,0,0);
        add(0,0,6'h08,1, 3,1,0);
        add(0,0,6'h06,1, 3,1,1);
        add(0,0,6'h06,1, 1,1,0);
        add(0,0,6'h00,1, 1,1,1);
        add(0,0,6'h00,0, 1,0,0);
        // MAX_BURST=1, full load, then all requests drop.
        add(1,1,6'h00,0, 0,0,0);
        add(0,1,6'h3F,1, 0,0,0);
        add(0,1,6'h3F,1, 0,1,1);
        add(0,1,6'h3F,1, 1,1,1);
        add(0,1,6'h3F,1, 2,1,1);
        add(0,1,6'h3F,1, 3,1,1);
        add(0,1,6'h3F,1, 4,1,1);
        add(0,1,6'h3F,1, 5,1,1);
        add(0,1,6'h00,1, 0,1,1);
        add(0,1,6'h00,0, 0,0,0);

        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            areset_n = !vecs[i].rst;
            req_a = vecs[i].b ? 6'h00 : vecs[i].req;
            rdy_a = vecs[i].b ? 1'b0  : vecs[i].rdy;
            req_b = vecs[i].b ? vecs[i].req : 6'h00;
            rdy_b = vecs[i].b ? vecs[i].rdy : 1'b0;
            #1;
            check_all($sformatf("row%0d", i), vecs[i].b, vecs[i].sel, vecs[i].vld, vecs[i].last);
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
